// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   - state_t             : loader FSM state encoding (3 bits)
//   - IMEM_DEPTH          : instruction memory size in bytes
//   - LEN_ZERO_MEANS_MAX  : byte count encoded by a LEN byte of zero
//   - frame_len()         : converts a LEN byte into a data byte count
//   - is_ready_state()    : states in which the stream interface accepts bytes
package imem_loader_pkg;

  localparam int IMEM_DEPTH         = 256;
  localparam int LEN_ZERO_MEANS_MAX = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_S  = 3'd1,
    BASE_S = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // A LEN byte of zero stands for a full-memory image.
  function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? 9'(LEN_ZERO_MEANS_MAX) : {1'b0, len_byte};
  endfunction

  function automatic logic is_ready_state(input state_t s);
    return (s == LEN_S) || (s == BASE_S) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// imem_byte_ram: byte-wide instruction memory.
//   clk    in   clock
//   we     in   write enable (synchronous)
//   waddr  in   write byte address
//   wdata  in   write byte
//   raddr  in   fetch byte address
//   rdata  out  {mem[raddr], mem[raddr+1], mem[raddr+2], mem[raddr+3]},
//               addresses wrap modulo DEPTH
module imem_byte_ram
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset; its contents must survive a Reset pulse.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // DEPTH == 2**ADDR_W, so ADDR_W-bit addition wraps exactly modulo DEPTH.
  logic [ADDR_W-1:0] raddr1, raddr2, raddr3;
  assign raddr1 = raddr + ADDR_W'(1);
  assign raddr2 = raddr + ADDR_W'(2);
  assign raddr3 = raddr + ADDR_W'(3);

  assign rdata = {mem[raddr], mem[raddr1], mem[raddr2], mem[raddr3]};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream writer for the instruction memory plus the
// big-endian 32-bit fetch port for the IF stage.
// Frame: LEN, BASE, N data bytes, [CHK]. LEN = 0 means 256 bytes.
// Build option: define IMEM_LOADER_CHECKSUM_EN to add the CHK byte, the data
// checksum and the sticky load_error flag.
//   clk          in   clock
//   Reset        in   asynchronous active-high reset
//   start        in   begin a session (sampled in IDLE only)
//   in_valid     in   stream byte valid
//   in_data      in   stream byte
//   in_ready     out  loader accepts a byte this cycle
//   load_busy    out  session in progress (pipeline hold)
//   load_done    out  one-cycle pulse on successful completion
//   load_error   out  sticky checksum failure (0 without the checksum build)
//   bytes_loaded out  data bytes written in the current/last session
//   fetch_addr   in   IF byte address
//   fetch_instr  out  big-endian instruction word at fetch_addr
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error,
  output logic [8:0]        bytes_loaded,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_instr
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] wptr;
  logic [8:0]        n_len;
  logic              hs;
  logic              we;
  logic              last_byte;

  assign hs        = in_valid && in_ready;
  assign we        = (state == DATA) && hs;
  assign last_byte = (bytes_loaded + 9'd1) == n_len;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] acc;
  logic [7:0] chk_sum;
  logic       chk_pass;
  assign chk_sum  = acc + in_data;
  assign chk_pass = (chk_sum == 8'd0);
`endif

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start) state_next = LEN_S;
      LEN_S:  if (hs)    state_next = BASE_S;
      BASE_S: if (hs)    state_next = DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      DATA:   if (hs && last_byte) state_next = CHK;
      CHK:    if (hs)    state_next = chk_pass ? DONE : ERR;
`else
      DATA:   if (hs && last_byte) state_next = DONE;
`endif
      DONE:   state_next = IDLE;
      ERR:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register itself.
  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      load_busy    <= 1'b0;
      load_done    <= 1'b0;
      bytes_loaded <= 9'd0;
      wptr         <= '0;
      n_len        <= 9'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc          <= 8'd0;
      load_error   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      in_ready  <= is_ready_state(state_next);
      load_busy <= (state_next != IDLE);
      load_done <= (state_next == DONE);

      if (state == IDLE && start) begin
        bytes_loaded <= 9'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc          <= 8'd0;
        load_error   <= 1'b0;
`endif
      end

      if (state == LEN_S && hs)  n_len <= frame_len(in_data);
      if (state == BASE_S && hs) wptr  <= ADDR_W'(in_data);

      if (we) begin
        wptr         <= wptr + ADDR_W'(1);
        bytes_loaded <= bytes_loaded + 9'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc          <= acc + in_data;
`endif
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == CHK && hs && !chk_pass) load_error <= 1'b1;
`endif
    end
  end

`ifndef IMEM_LOADER_CHECKSUM_EN
  assign load_error = 1'b0;
`endif

  imem_byte_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr),
    .wdata (in_data),
    .raddr (fetch_addr),
    .rdata (fetch_instr)
  );

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader. Stimulus is a mix of
// directed frames and randomized frames; expected memory contents, counts and
// flags come from a byte-array model of the frame rules.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  logic [8:0]  bytes_loaded;
  logic [7:0]  fetch_addr;
  logic [31:0] fetch_instr;

  imem_loader dut (
    .clk          (clk),
    .Reset        (Reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .load_error   (load_error),
    .bytes_loaded (bytes_loaded),
    .fetch_addr   (fetch_addr),
    .fetch_instr  (fetch_instr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [7:0] ref_mem   [256];
  bit         ref_known [256];
  logic [7:0] frame     [256];

  always @(negedge clk) if (load_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] good_chk(input int n);
    int sum = 0;
    for (int i = 0; i < n; i++) sum += frame[i];
    return 8'((256 - (sum % 256)) % 256);
  endfunction

  task automatic check_byte(input int a);
    if (ref_known[a]) begin
      fetch_addr = 8'(a);
      #1;
      check("mem_byte", {24'd0, fetch_instr[31:24]}, {24'd0, ref_mem[a]});
    end
  endtask

  task automatic check_fetch(input int a);
    bit          all_known = 1'b1;
    logic [31:0] exp = '0;
    for (int i = 0; i < 4; i++) begin
      all_known &= ref_known[(a + i) % 256];
      exp = {exp[23:0], ref_mem[(a + i) % 256]};
    end
    if (all_known) begin
      fetch_addr = 8'(a);
      #1;
      check("fetch_word", fetch_instr, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit noise);
    int  g;
    bit  rdy;
    bit  taken = 1'b0;
    g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    if (noise) start = 1'($urandom_range(0, 1));
    for (int k = 0; k < 64 && !taken; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) taken = 1'b1;
    end
    if (!taken) check("hs_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_ready", {31'd0, in_ready},  32'd1);
    check("start_busy",  {31'd0, load_busy}, 32'd1);
    check("start_bytes", {23'd0, bytes_loaded}, 32'd0);
    check("start_err_clr", {31'd0, load_error}, 32'd0);
  endtask

  task automatic run_session(input logic [7:0] len_b, input logic [7:0] base_b,
                             input logic [7:0] chk_b, input int gap_mode, input bit noise);
    int n;
    int sum = 0;
    bit exp_err;
    int d0;
    n = (len_b == 8'd0) ? 256 : int'(len_b);
    for (int i = 0; i < n; i++) sum += frame[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = ((sum + int'(chk_b)) % 256) != 0;
`else
    exp_err = 1'b0;
`endif
    do_start();
    d0 = done_cnt;
    send_byte(len_b, gap_mode, 1'b0);
    send_byte(base_b, gap_mode, 1'b0);
    for (int i = 0; i < n; i++) begin
      send_byte(frame[i], gap_mode, noise);
      ref_mem[(int'(base_b) + i) % 256]   = frame[i];
      ref_known[(int'(base_b) + i) % 256] = 1'b1;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(chk_b, gap_mode, 1'b0);
`endif
    check("done_pulse",   {31'd0, load_done},  {31'd0, !exp_err});
    check("busy_last",    {31'd0, load_busy},  32'd1);
    check("err_flag",     {31'd0, load_error}, {31'd0, exp_err});
    check("bytes_loaded", {23'd0, bytes_loaded}, 32'(n));
    @(posedge clk); #1;
    check("busy_fall",  {31'd0, load_busy}, 32'd0);
    check("done_clear", {31'd0, load_done}, 32'd0);
    check("ready_idle", {31'd0, in_ready},  32'd0);
    check("done_count", 32'(done_cnt - d0), exp_err ? 32'd0 : 32'd1);
    check("err_sticky", {31'd0, load_error}, {31'd0, exp_err});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready},   32'd0);
    check({tag, "_busy"},  {31'd0, load_busy},  32'd0);
    check({tag, "_done"},  {31'd0, load_done},  32'd0);
    check({tag, "_err"},   {31'd0, load_error}, 32'd0);
    check({tag, "_bytes"}, {23'd0, bytes_loaded}, 32'd0);
  endtask

  initial begin
    int         len;
    logic [7:0] base;
    logic [7:0] chk;

    Reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; fetch_addr = 8'd0;
    for (int i = 0; i < 256; i++) begin ref_known[i] = 1'b0; ref_mem[i] = 8'd0; end
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    Reset = 1'b0;
    @(posedge clk); #1;

    // Basic load at address 0.
    frame[0] = 8'hE0; frame[1] = 8'h81; frame[2] = 8'h00; frame[3] = 8'h02;
    run_session(8'd4, 8'h00, good_chk(4), 0, 1'b0);
    fetch_addr = 8'h00; #1;
    check("t1_word", fetch_instr, 32'hE0810002);

    // Write pointer wrap across the top of memory.
    frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33; frame[3] = 8'h44;
    run_session(8'd4, 8'hFE, good_chk(4), 0, 1'b0);
    fetch_addr = 8'hFE; #1;
    check("wrap_word", fetch_instr, 32'h11223344);
    check_byte(0);
    check_byte(1);
    check_fetch(253);
    check_fetch(255);

    // Backpressure: one idle cycle before every byte.
    frame[0] = 8'hE0; frame[1] = 8'h81; frame[2] = 8'h00; frame[3] = 8'h02;
    run_session(8'd4, 8'h00, good_chk(4), 1, 1'b0);
    fetch_addr = 8'h00; #1;
    check("bp_word", fetch_instr, 32'hE0810002);
    check_fetch(2);

    // Checksum pass, then fail; the next start clears the error flag.
    frame[0] = 8'h01; frame[1] = 8'h02; frame[2] = 8'h03;
    run_session(8'd3, 8'h40, 8'hFA, 0, 1'b0);
    run_session(8'd3, 8'h40, 8'h00, 0, 1'b0);
    check_fetch(8'h40);

    // in_valid while idle must not write anything.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      check("idle_not_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Asynchronous reset in the middle of DATA.
    base = 8'($urandom);
    do_start();
    send_byte(8'd4, 0, 1'b0);
    send_byte(base, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      frame[i] = 8'($urandom);
      send_byte(frame[i], 0, 1'b0);
      ref_mem[(int'(base) + i) % 256]   = frame[i];
      ref_known[(int'(base) + i) % 256] = 1'b1;
    end
    check("mid_bytes", {23'd0, bytes_loaded}, 32'd2);
    #2 Reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    Reset = 1'b0;
    check_byte(int'(base));
    check_byte((int'(base) + 1) % 256);
    for (int i = 0; i < 6; i++) frame[i] = 8'($urandom);
    run_session(8'd6, 8'($urandom), good_chk(6), 2, 1'b0);

    // Full-memory image (LEN = 0) with start pulses during DATA.
    for (int i = 0; i < 256; i++) frame[i] = 8'($urandom);
    run_session(8'd0, 8'($urandom), good_chk(256), 0, 1'b1);

    // Randomized sessions: random length, base, gaps, good or random CHK.
    for (int s = 0; s < 8; s++) begin
      len  = int'($urandom_range(1, 40));
      base = 8'($urandom);
      for (int i = 0; i < len; i++) frame[i] = 8'($urandom);
      chk  = ($urandom_range(0, 1) == 1) ? good_chk(len) : 8'($urandom);
      run_session(8'(len), base, chk, 2, 1'($urandom_range(0, 1)));
    end

    for (int a = 0; a < 256; a++) check_byte(a);
    for (int i = 0; i < 16; i++) check_fetch(int'($urandom_range(0, 255)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
